// File: rtl/pfx_serializer_if.sv
// pfx_serializer_if: vector capture and element stream bundle for pfx_serializer.
// slave is the serializer side, master is the upstream/sink side.
interface pfx_serializer_if #(
  parameter int IWIDTH = 8,
  parameter int V_LEN  = 8
);
  localparam int IW = $clog2(V_LEN);

  logic                     valid_in;
  logic [IWIDTH*V_LEN-1:0]  ivec;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [IWIDTH-1:0]        out_data;
  logic [IW-1:0]            out_idx;
  logic                     out_last;
  logic [15:0]              drop_cnt;

  modport master (
    output valid_in, ivec, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
  );

  modport slave (
    input  valid_in, ivec, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
  );
endinterface

// File: rtl/pfx_serializer.sv
// pfx_serializer: captures a prefix-sum vector on a one-cycle pulse and streams
// its elements out one per valid/ready beat, index 0 first. Vectors that cannot
// be stored are dropped and counted (saturating 16-bit counter).
// Optional build macro PFX_SER_DBLBUF_EN adds one pending vector slot so a
// second vector can wait behind the draining one and follow with no bubble.
module pfx_serializer #(
  parameter int IWIDTH = 8,
  parameter int V_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  pfx_serializer_if.slave     bus
);

  localparam int IW = $clog2(V_LEN);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(V_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                         state_r;
  state_t                         state_nxt_s;
  logic [V_LEN-1:0][IWIDTH-1:0]   act_r;
  logic [IW-1:0]                  idx_r;
  logic [IW-1:0]                  idx_nxt_s;
  logic [IWIDTH-1:0]              out_data_r;
  logic                           out_valid_r;
  logic                           out_last_r;
  logic [15:0]                    drop_cnt_r;

  logic                           in_ready_s;
  logic                           capture_s;
  logic                           drop_s;
  logic                           load_act_s;
  logic                           swap_s;
  logic                           adv_s;
  logic                           pend_vld_s;
  logic [V_LEN-1:0][IWIDTH-1:0]   pend_data_s;

`ifdef PFX_SER_DBLBUF_EN
  logic                           pend_vld_r;
  logic [V_LEN-1:0][IWIDTH-1:0]   pend_r;
  logic                           pend_load_s;

  // A vector captured while draining parks in the pending slot, unless it
  // arrives on the last beat with the slot empty, where it loads directly.
  assign pend_load_s = capture_s && (state_r == DRAIN) && !load_act_s;

  // Pending slot: filled on a parked capture, emptied when promoted to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_r <= 1'b0;
      pend_r     <= '0;
    end else if (pend_load_s) begin
      pend_vld_r <= 1'b1;
      pend_r     <= bus.ivec;
    end else if (swap_s) begin
      pend_vld_r <= 1'b0;
    end
  end

  assign pend_vld_s  = pend_vld_r;
  assign pend_data_s = pend_r;
  assign in_ready_s  = (state_r == IDLE) || !pend_vld_r;
`else
  assign pend_vld_s  = 1'b0;
  assign pend_data_s = '0;
  assign in_ready_s  = (state_r == IDLE);
`endif

  assign capture_s = bus.valid_in && in_ready_s;
  assign drop_s    = bus.valid_in && !in_ready_s;

  // Next-state and datapath control: load, advance, or promote pending.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_act_s  = 1'b0;
    swap_s      = 1'b0;
    adv_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          load_act_s  = 1'b1;
          idx_nxt_s   = IDX_ZERO;
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_r == IDX_LAST) begin
            if (pend_vld_s) begin
              swap_s    = 1'b1;
              idx_nxt_s = IDX_ZERO;
            end else if (capture_s) begin
              load_act_s = 1'b1;
              idx_nxt_s  = IDX_ZERO;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            adv_s     = 1'b1;
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Active buffer, index and registered stream outputs; held during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_r       <= '0;
      idx_r       <= IDX_ZERO;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      out_valid_r <= (state_nxt_s == DRAIN);
      out_last_r  <= (state_nxt_s == DRAIN) && (idx_nxt_s == IDX_LAST);
      if (load_act_s) begin
        act_r      <= bus.ivec;
        out_data_r <= bus.ivec[IWIDTH-1:0];
      end else if (swap_s) begin
        act_r      <= pend_data_s;
        out_data_r <= pend_data_s[IDX_ZERO];
      end else if (adv_s) begin
        out_data_r <= act_r[idx_nxt_s];
      end
    end
  end

  // Saturating count of vectors that arrived with no free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = idx_r;
  assign bus.out_last  = out_last_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pfx_serializer.sv
// tb_pfx_serializer: directed and randomized checks of pfx_serializer against a
// queue-of-beats reference model. Works for both buffer configurations.
module tb_pfx_serializer;

  localparam int IWIDTH = 8;
  localparam int V_LEN  = 8;
  localparam int IW     = $clog2(V_LEN);
`ifdef PFX_SER_DBLBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [IWIDTH-1:0] val;
    logic [IW-1:0]     idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pfx_serializer_if #(.IWIDTH(IWIDTH), .V_LEN(V_LEN)) bus ();

  pfx_serializer #(.IWIDTH(IWIDTH), .V_LEN(V_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t                     q[$];
  int                        m_drop;
  int                        n_checks;
  int                        n_fail;
  logic                      drv_vi;
  logic                      drv_ordy;
  logic [IWIDTH*V_LEN-1:0]   drv_vec;

  function automatic logic [IWIDTH*V_LEN-1:0] tri_vec();
    logic [IWIDTH*V_LEN-1:0] v;
    for (int i = 0; i < V_LEN; i++) v[i*IWIDTH +: IWIDTH] = IWIDTH'((i + 1) * (i + 2) / 2);
    return v;
  endfunction

  function automatic logic [IWIDTH*V_LEN-1:0] even_vec();
    logic [IWIDTH*V_LEN-1:0] v;
    for (int i = 0; i < V_LEN; i++) v[i*IWIDTH +: IWIDTH] = IWIDTH'(2 * (i + 1));
    return v;
  endfunction

  function automatic int held_vectors();
    return (q.size() + V_LEN - 1) / V_LEN;
  endfunction

  // Drive inputs for the coming cycle, away from the active edge.
  task automatic set_inputs(input logic vi, input logic [IWIDTH*V_LEN-1:0] vec,
                            input logic ordy, input logic r);
    @(negedge clk);
    rst           = r;
    drv_vi        = vi;
    drv_vec       = vec;
    drv_ordy      = ordy;
    bus.valid_in  = vi;
    bus.ivec      = vec;
    bus.out_ready = ordy;
  endtask

  // Reference model: a vector is accepted when fewer than CAP vectors are held.
  task automatic advance();
    int    held;
    beat_t b;
    held = held_vectors();
    if (rst) begin
      q.delete();
      m_drop = 0;
    end else begin
      if (q.size() > 0 && drv_ordy) void'(q.pop_front());
      if (drv_vi) begin
        if (held < CAP) begin
          for (int i = 0; i < V_LEN; i++) begin
            b.val = drv_vec[i*IWIDTH +: IWIDTH];
            b.idx = IW'(i);
            q.push_back(b);
          end
        end else if (m_drop != 65535) begin
          m_drop++;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    set_inputs(1'b1, tri_vec(), 1'b0, 1'b1);
    advance();
    set_inputs(1'b1, tri_vec(), 1'b0, 1'b1);
    advance();
    set_inputs(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++;
    if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", bus.drop_cnt); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++;
    if ({bus.out_data, bus.out_idx, bus.out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got d=%0d i=%0d l=%b exp all 0", bus.out_data, bus.out_idx, bus.out_last);
    end
    advance();
    set_inputs(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_capture got out_valid=%b exp 0", bus.out_valid); end
    advance();
  endtask

  task automatic test_basic_drain();
    int n_beats;
    int n_last;
    logic ok;
    n_beats = 0;
    n_last  = 0;
    set_inputs(1'b1, tri_vec(), 1'b1, 1'b0);
    advance();
    for (int c = 0; c < V_LEN + 2; c++) begin
      set_inputs(1'b0, '0, 1'b1, 1'b0);
      if (q.size() == 0) ok = (bus.out_valid === 1'b0);
      else ok = (bus.out_valid === 1'b1) && (bus.out_data === q[0].val) && (bus.out_idx === q[0].idx)
                && (bus.out_last === (q[0].idx == IW'(V_LEN - 1)));
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL basic_beat c=%0d got v=%b d=%0d i=%0d l=%b exp beats_left=%0d", c, bus.out_valid,
                 bus.out_data, bus.out_idx, bus.out_last, q.size());
      end
      if (c == 0) begin
        n_checks++;
        if (bus.out_data !== 8'd1) begin n_fail++; $display("FAIL basic_first got %0d exp 1", bus.out_data); end
      end
      if (bus.out_valid === 1'b1) n_beats++;
      if (bus.out_last === 1'b1) n_last++;
      advance();
    end
    n_checks++;
    if (n_beats != V_LEN) begin n_fail++; $display("FAIL basic_beat_count got %0d exp %0d", n_beats, V_LEN); end
    n_checks++;
    if (n_last != 1) begin n_fail++; $display("FAIL basic_last_count got %0d exp 1", n_last); end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   n_xfer;
    logic prev_stall;
    logic [IWIDTH+IW:0] prev_out;
    logic ok;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_xfer = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    set_inputs(1'b1, tri_vec(), 1'b0, 1'b0);
    advance();
    for (int c = 0; c < 4 * V_LEN + 4; c++) begin
      set_inputs(1'b0, '0, pat[c % 4], 1'b0);
      if (q.size() == 0) ok = (bus.out_valid === 1'b0);
      else ok = (bus.out_valid === 1'b1) && (bus.out_data === q[0].val) && (bus.out_idx === q[0].idx)
                && (bus.out_last === (q[0].idx == IW'(V_LEN - 1)));
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL bp_beat c=%0d got v=%b d=%0d i=%0d l=%b exp beats_left=%0d", c, bus.out_valid,
                 bus.out_data, bus.out_idx, bus.out_last, q.size());
      end
      if (prev_stall) begin
        n_checks++;
        if ({bus.out_data, bus.out_idx, bus.out_last} !== prev_out) begin
          n_fail++; $display("FAIL bp_stable c=%0d got %h exp %h", c, {bus.out_data, bus.out_idx, bus.out_last}, prev_out);
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && !pat[c % 4];
      prev_out   = {bus.out_data, bus.out_idx, bus.out_last};
      if (bus.out_valid === 1'b1 && pat[c % 4]) n_xfer++;
      advance();
    end
    n_checks++;
    if (n_xfer != V_LEN) begin n_fail++; $display("FAIL bp_xfer_count got %0d exp %0d", n_xfer, V_LEN); end
  endtask

  task automatic test_drop();
    int   nb;
    int   n_beats;
    logic vi;
    logic ok;
    nb = 0;
    n_beats = 0;
    set_inputs(1'b1, tri_vec(), 1'b1, 1'b0);
    advance();
    for (int c = 0; c < 2 * V_LEN + 4; c++) begin
      vi = (nb == 3) || (nb == V_LEN - 1);
      set_inputs(vi, even_vec(), 1'b1, 1'b0);
      if (q.size() == 0) ok = (bus.out_valid === 1'b0);
      else ok = (bus.out_valid === 1'b1) && (bus.out_data === q[0].val) && (bus.out_idx === q[0].idx)
                && (bus.out_last === (q[0].idx == IW'(V_LEN - 1)));
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL drop_beat c=%0d got v=%b d=%0d i=%0d l=%b exp beats_left=%0d", c, bus.out_valid,
                 bus.out_data, bus.out_idx, bus.out_last, q.size());
      end
      n_checks++;
      if (bus.drop_cnt !== 16'(m_drop)) begin
        n_fail++; $display("FAIL drop_cnt_timing c=%0d got %0d exp %0d", c, bus.drop_cnt, m_drop);
      end
      if (q.size() > 0) nb++;
      if (bus.out_valid === 1'b1) n_beats++;
      advance();
    end
    n_checks++;
    if (bus.drop_cnt !== 16'(CAP == 1 ? 2 : 1)) begin
      n_fail++; $display("FAIL drop_total got %0d exp %0d", bus.drop_cnt, (CAP == 1 ? 2 : 1));
    end
    n_checks++;
    if (n_beats != CAP * V_LEN) begin
      n_fail++; $display("FAIL drop_beats got %0d exp %0d", n_beats, CAP * V_LEN);
    end
  endtask

  task automatic test_mid_drain_reset();
    bit   found;
    logic ok;
    found = 1'b0;
    set_inputs(1'b1, tri_vec(), 1'b1, 1'b0);
    advance();
    for (int c = 0; c < 20 && !found; c++) begin
      if (q.size() > 0 && q[0].idx == IW'(4)) begin
        found = 1'b1;
        set_inputs(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_idx !== IW'(4)) begin n_fail++; $display("FAIL mid_rst_idx got %0d exp 4", bus.out_idx); end
      end else begin
        set_inputs(1'b0, '0, 1'b1, 1'b0);
      end
      advance();
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_rst_reach got idx_not_reached exp idx 4"); end
    set_inputs(1'b1, even_vec(), 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
    n_checks++;
    if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_drop got %0d exp 0", bus.drop_cnt); end
    advance();
    for (int c = 0; c < V_LEN + 1; c++) begin
      set_inputs(1'b0, '0, 1'b1, 1'b0);
      if (q.size() == 0) ok = (bus.out_valid === 1'b0);
      else ok = (bus.out_valid === 1'b1) && (bus.out_data === q[0].val) && (bus.out_idx === q[0].idx)
                && (bus.out_last === (q[0].idx == IW'(V_LEN - 1)));
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL mid_rst_beat c=%0d got v=%b d=%0d i=%0d l=%b exp beats_left=%0d", c, bus.out_valid,
                 bus.out_data, bus.out_idx, bus.out_last, q.size());
      end
      if (c == 0) begin
        n_checks++;
        if (bus.out_idx !== IW'(0) || bus.out_data !== 8'd2) begin
          n_fail++; $display("FAIL mid_rst_restart got i=%0d d=%0d exp i=0 d=2", bus.out_idx, bus.out_data);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [IWIDTH*V_LEN-1:0] v;
    logic vi;
    logic ordy;
    logic ok;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < V_LEN; i++) v[i*IWIDTH +: IWIDTH] = IWIDTH'($urandom);
      vi   = ($urandom_range(0, 5) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      set_inputs(vi, v, ordy, 1'b0);
      if (q.size() == 0) ok = (bus.out_valid === 1'b0);
      else ok = (bus.out_valid === 1'b1) && (bus.out_data === q[0].val) && (bus.out_idx === q[0].idx)
                && (bus.out_last === (q[0].idx == IW'(V_LEN - 1)));
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_beat c=%0d got v=%b d=%0d i=%0d l=%b exp beats_left=%0d", c, bus.out_valid,
                 bus.out_data, bus.out_idx, bus.out_last, q.size());
      end
      n_checks++;
      if (bus.in_ready !== (held_vectors() < CAP)) begin
        n_fail++; $display("FAIL rand_in_ready c=%0d got %b exp %b", c, bus.in_ready, (held_vectors() < CAP));
      end
      n_checks++;
      if (bus.drop_cnt !== 16'(m_drop)) begin
        n_fail++; $display("FAIL rand_drop_cnt c=%0d got %0d exp %0d", c, bus.drop_cnt, m_drop);
      end
      advance();
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_drop        = 0;
    drv_vi        = 1'b0;
    drv_ordy      = 1'b0;
    drv_vec       = '0;
    bus.valid_in  = 1'b0;
    bus.ivec      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_drop();
    test_mid_drain_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
